cnn_axis_pixel_unpacker: RTL
============================

// Module: cnn_axis_pixel_unpacker
// PURPOSE
//  Upstream stage of cnn_top. Accepts 32-bit AXI-Stream beats from DMA and serialises them into 8-bit pixels
//  (byte 0 first) on the d_in/in_valid pair of cnn_top, so all four bytes per beat are used.
//  Tracks pixels per frame, drives pix_last on the final pixel, flags tlast/frame-size mismatches.
// PARAMETERS
//  DATA_W        32   input beat width; must be 4*PIX_W
//  PIX_W         8    pixel width
//  FRAME_PIXELS  784  pixels per frame (28x28); counter width = $clog2(FRAME_PIXELS)
// PORTS
//  clk            in   1       system clock, all logic rising edge
//  rst_n          in   1       asynchronous active-low reset
//  s_axis_tdata   in   DATA_W  input beat, byte i = tdata[8i+7:8i]
//  s_axis_tstrb   in   4       byte strobes (used only with CNN_UNPACK_STRB_EN)
//  s_axis_tlast   in   1       last beat of frame
//  s_axis_tvalid  in   1       beat valid
//  s_axis_tready  out  1       beat accepted when tvalid & tready
//  pix_out        out  PIX_W   pixel to cnn_top d_in
//  pix_valid      out  1       pixel valid (cnn_top in_valid)
//  pix_last       out  1       qualifies pixel index FRAME_PIXELS-1
//  pix_ready      in   1       downstream accept; tie 1 for cnn_top
//  frame_err      out  1       sticky frame-size/tlast mismatch
//  err_clr        in   1       synchronous clear of frame_err
// BEHAVIOUR
//  Reset: s_axis_tready=0 during reset, 1 first cycle after; pix_out=0, pix_valid=0, pix_last=0, frame_err=0;
//   held word, byte index, pixel count cleared. Reset mid-word discards the partial word and frame.
//  Storage: one word register + 4-bit byte-enable mask + tlast flag; states IDLE (no word) / EMIT (word held).
//  s_axis_tready = (state==IDLE) | (pix_ready & current byte is last enabled byte of held word).
//  IDLE: beat accepted -> EMIT next cycle; pix_valid=1 with first enabled byte in cycle N+1 (latency 1).
//  EMIT: on pix_valid & pix_ready advance to next enabled byte (ascending index); after last enabled byte:
//   new beat accepted same cycle -> stay EMIT, its first byte next cycle (no bubble, 1 pixel/clk sustained);
//   no beat -> IDLE, pix_valid=0.
//  pix_ready=0: pix_out, pix_valid, pix_last and all state hold; no beat accepted unless IDLE.
//  Pixel count: +1 per transferred pixel; pix_last = (count==FRAME_PIXELS-1) & pix_valid; wraps to 0 after it.
//  Frame check at last enabled byte of a tlast word: byte not the pix_last pixel -> frame_err=1, count forced 0.
//   pix_last pixel that is not last byte of a tlast word -> frame_err=1; count wraps normally.
//  Zero-enable beat: accepted, emits nothing, state unchanged; if tlast, count!=0 -> frame_err=1, count forced 0.
//  err_clr same cycle as new error: set wins. frame_err only cleared by err_clr or reset.
// CONFIGURATION
//  CNN_UNPACK_STRB_EN defined: byte-enable mask = s_axis_tstrb at accept; bytes with strb=0 skipped (no gap cycle).
//  Undefined: mask forced 4'b1111; tstrb ignored; exactly 4 pixels per beat.
// TESTING
//  Single beat 0x44332211, tlast=0, pix_ready=1 -> pix_out 0x11,0x22,0x33,0x44 in 4 consecutive cycles from N+1.
//  196 back-to-back beats, tlast on 196th -> 784 pixels, no bubbles, pix_last only on pixel 783, frame_err=0.
//  pix_ready low 3 cycles mid-word -> pix_out/pix_valid frozen, s_axis_tready=0, no pixel lost or duplicated.
//  tlast on beat 10 (40 pixels) -> frame_err=1 after 40th pixel; next frame of 196 beats -> clean pix_last at 783.
//  STRB_EN, beat 0xDDCCBBAA tstrb=4'b1010 -> pixels 0xBB,0xDD only; macro off -> all four bytes.
//  rst_n low during byte 2 of a word -> outputs 0 immediately; after release first new beat yields count 0 byte 0.

Source files
------------

// File: rtl/cnn_axis_pixel_unpacker.sv
// Serialises 32-bit AXI-Stream beats into 8-bit pixels (byte 0 first) with per-frame pixel counting.
// Optional byte-strobe skipping is enabled by defining CNN_UNPACK_STRB_EN.
module cnn_axis_pixel_unpacker #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned PIX_W        = 8,
    parameter int unsigned FRAME_PIXELS = 784
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         s_axis_tdata,
    input  logic [DATA_W/PIX_W-1:0]   s_axis_tstrb,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [PIX_W-1:0]          pix_out,
    output logic                      pix_valid,
    output logic                      pix_last,
    input  logic                      pix_ready,
    output logic                      frame_err,
    input  logic                      err_clr
);

    localparam int unsigned NB    = DATA_W / PIX_W;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CNT_W = $clog2(FRAME_PIXELS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_PIXELS - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [NB-1:0]       mask_q, mask_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                tlast_q, tlast_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PIX_W-1:0]    pix_out_q, pix_out_d;
    logic                pix_valid_q, pix_valid_d;
    logic                pix_last_q, pix_last_d;
    logic                err_q, err_d;
    logic                live_q;

    logic [NB-1:0]       beat_mask;
    logic [NB-1:0]       cur_bit;
    logic [NB-1:0]       rem_mask;
    logic                cur_last;
    logic                at_max;
    logic                xfer;
    logic                accept;
    logic                new_err;

    function automatic logic [IDX_W-1:0] first_idx(input logic [NB-1:0] m);
        first_idx = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (m[i]) first_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [PIX_W-1:0] pick(input logic [DATA_W-1:0] w, input logic [IDX_W-1:0] i);
        pick = PIX_W'(w >> (PIX_W * int'(i)));
    endfunction

`ifdef CNN_UNPACK_STRB_EN
    assign beat_mask = s_axis_tstrb;
`else
    logic unused_strb;
    assign beat_mask   = '1;
    assign unused_strb = ^s_axis_tstrb;
`endif

    // Bytes still to emit after the one currently presented
    assign cur_bit  = NB'(1) << idx_q;
    assign rem_mask = mask_q & ~cur_bit;
    assign cur_last = (rem_mask == '0);
    assign at_max   = (cnt_q == CNT_MAX);
    assign xfer     = pix_valid_q & pix_ready;

    assign s_axis_tready = live_q & ((state_q == IDLE) | (pix_ready & cur_last));
    assign accept        = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        mask_d      = mask_q;
        idx_d       = idx_q;
        tlast_d     = tlast_q;
        cnt_d       = cnt_q;
        pix_out_d   = pix_out_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        new_err     = 1'b0;

        if (xfer) begin
            cnt_d = at_max ? '0 : cnt_q + CNT_W'(1);
            // End of a tlast word must coincide with the frame's last pixel
            if ((cur_last & tlast_q) != at_max) begin
                new_err = 1'b1;
                cnt_d   = '0;
            end
            if (!cur_last) begin
                mask_d     = rem_mask;
                idx_d      = first_idx(rem_mask);
                pix_out_d  = pick(word_q, first_idx(rem_mask));
                pix_last_d = (cnt_d == CNT_MAX);
            end else begin
                state_d     = IDLE;
                mask_d      = '0;
                pix_valid_d = 1'b0;
                pix_last_d  = 1'b0;
            end
        end

        if (accept) begin
            if (beat_mask != '0) begin
                state_d     = EMIT;
                word_d      = s_axis_tdata;
                mask_d      = beat_mask;
                idx_d       = first_idx(beat_mask);
                tlast_d     = s_axis_tlast;
                pix_out_d   = pick(s_axis_tdata, first_idx(beat_mask));
                pix_valid_d = 1'b1;
                pix_last_d  = (cnt_d == CNT_MAX);
            end else if (s_axis_tlast && (cnt_d != '0)) begin
                new_err = 1'b1;
                cnt_d   = '0;
            end
        end

        err_d = (err_q & ~err_clr) | new_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            mask_q      <= '0;
            idx_q       <= '0;
            tlast_q     <= 1'b0;
            cnt_q       <= '0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            err_q       <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            mask_q      <= mask_d;
            idx_q       <= idx_d;
            tlast_q     <= tlast_d;
            cnt_q       <= cnt_d;
            pix_out_q   <= pix_out_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            err_q       <= err_d;
            live_q      <= 1'b1;
        end
    end

    assign pix_out   = pix_out_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign frame_err = err_q;

endmodule
